// File: rtl/mem_serializer_pkg.sv
// Shared types and default widths for the multiport-to-single-port memory serializer.
package mem_serializer_pkg;

  localparam int unsigned ADDR_W_DEF = 14;
  localparam int unsigned DATA_W_DEF = 10;
  localparam int unsigned N_RD_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_serializer_pick.sv
// Fixed-priority picker: lowest set bit of the pending mask wins (reads first, write in MSB).
module mem_serializer_pick #(
  parameter int unsigned N     = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     pending,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    grant = '0;
    index = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        index    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_port_serializer.sv
// Serializes a cycle's 4-read/1-write CPU requests onto one single-port SRAM,
// holding the CPU via cpu_clken until every read result is in place.
module mem_port_serializer
  import mem_serializer_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned N_RD   = N_RD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_inaddr,
  input  logic [DATA_W-1:0]        req_indata,
  input  logic [N_RD-1:0]          req_read,
  input  logic [N_RD*ADDR_W-1:0]   req_outaddr,
  output logic [N_RD*DATA_W-1:0]   rsp_outdata,
  output logic                     cpu_clken,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata,
  output logic [1:0]               dbg_state
);

  localparam int unsigned IDX_W = $clog2(N_RD + 1);
  localparam int unsigned TAG_W = (N_RD > 1) ? $clog2(N_RD) : 1;

  state_t                  state, state_nxt;
  logic [N_RD:0]           pend_q, pend_nxt;
  logic [N_RD:0]           grant;
  logic [IDX_W-1:0]        idx;
  logic [N_RD*ADDR_W-1:0]  raddr_q;
  logic [ADDR_W-1:0]       waddr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    rd_vld_q;
  logic [TAG_W-1:0]        rd_tag_q;
  logic                    any_req;
  logic                    issue;
  logic                    is_wr;

  assign any_req = (|req_read) | req_write;
  assign issue   = (state == ISSUE) && (|pend_q);
  assign is_wr   = (idx == IDX_W'(N_RD));

  mem_serializer_pick #(
    .N     (N_RD + 1),
    .IDX_W (IDX_W)
  ) u_pick (
    .pending (pend_q),
    .grant   (grant),
    .index   (idx)
  );

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_q;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ISSUE;
          pend_nxt  = {req_write, req_read};
        end
      end
      ISSUE: begin
        pend_nxt = pend_q & ~grant;
        if (pend_nxt == '0) state_nxt = WAIT;
      end
      WAIT:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read data lands one cycle after its issue; the tag steers it to its port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pend_q      <= '0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      rd_vld_q    <= 1'b0;
      rd_tag_q    <= '0;
      rsp_outdata <= '0;
    end else begin
      state    <= state_nxt;
      pend_q   <= pend_nxt;
      rd_vld_q <= issue && !is_wr;
      rd_tag_q <= idx[TAG_W-1:0];
      if (state == IDLE && any_req) begin
        raddr_q <= req_outaddr;
        waddr_q <= req_inaddr;
        wdata_q <= req_indata;
      end
      if (rd_vld_q) rsp_outdata[rd_tag_q*DATA_W +: DATA_W] <= ram_rdata;
    end
  end

  always_comb begin
    ram_en    = issue;
    ram_we    = issue && is_wr;
    ram_addr  = '0;
    ram_wdata = '0;
    if (issue) begin
      ram_addr = is_wr ? waddr_q : raddr_q[idx[TAG_W-1:0]*ADDR_W +: ADDR_W];
      if (is_wr) ram_wdata = wdata_q;
    end
  end

  assign cpu_clken = rst && (((state == IDLE) && !any_req) || (state == DONE));
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_serializer.sv
// Directed plus randomized bench for mem_port_serializer with a behavioural SRAM and memory model.
module tb_mem_port_serializer;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 10;
  localparam int unsigned NR = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_write = 1'b0;
  logic [AW-1:0]     req_inaddr = '0;
  logic [DW-1:0]     req_indata = '0;
  logic [NR-1:0]     req_read = '0;
  logic [NR*AW-1:0]  req_outaddr = '0;
  logic [NR*DW-1:0]  rsp_outdata;
  logic              cpu_clken;
  logic              ram_en;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_rdata = '0;
  logic [1:0]        dbg_state;

  logic [DW-1:0]     ram     [1<<AW];
  logic [DW-1:0]     ref_mem [1<<AW];
  logic [DW-1:0]     exp_rsp [NR];
  int                checks = 0;
  int                errors = 0;

  mem_port_serializer dut (
    .clk         (clk),
    .rst         (rst),
    .req_write   (req_write),
    .req_inaddr  (req_inaddr),
    .req_indata  (req_indata),
    .req_read    (req_read),
    .req_outaddr (req_outaddr),
    .rsp_outdata (rsp_outdata),
    .cpu_clken   (cpu_clken),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // Single-port synchronous SRAM
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] = ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic chk_rsp(input string tag);
    for (int k = 0; k < int'(NR); k++) chk(tag, 32'(rsp_outdata[k*DW +: DW]), 32'(exp_rsp[k]));
  endtask

  // One CPU transaction; expectations come from the memory model, not the DUT.
  task automatic run_txn(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [NR-1:0] rm, input logic [NR*AW-1:0] ra);
    logic [AW-1:0] exp_ops[$];
    int low, nops, nwe;
    bit done;
    for (int k = 0; k < int'(NR); k++) if (rm[k]) exp_ops.push_back(ra[k*AW +: AW]);
    if (wr) exp_ops.push_back(wa);
    @(negedge clk);
    req_write = wr; req_inaddr = wa; req_indata = wd; req_read = rm; req_outaddr = ra;
    #1;
    chk("clken_on_capture", 32'(cpu_clken), 32'd0);
    low = 1; nops = 0; nwe = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      if (cpu_clken) done = 1'b1;
      else begin
        low++;
        if (ram_en) begin
          if (nops < exp_ops.size()) chk("op_addr", 32'(ram_addr), 32'(exp_ops[nops]));
          chk("op_we", 32'(ram_we), 32'(wr && (nops == exp_ops.size() - 1)));
          if (ram_we) begin
            chk("op_wdata", 32'(ram_wdata), 32'(wd));
            nwe++;
          end
          nops++;
        end
      end
    end
    chk("done_reached", 32'(done), 32'd1);
    chk("clken_low_cycles", 32'(low), 32'(exp_ops.size() + 2));
    chk("op_count", 32'(nops), 32'(exp_ops.size()));
    chk("write_count", 32'(nwe), 32'(wr));
    chk("done_state", 32'(dbg_state), 32'd3);
    for (int k = 0; k < int'(NR); k++) if (rm[k]) exp_rsp[k] = ref_mem[ra[k*AW +: AW]];
    if (wr) ref_mem[wa] = wd;
    chk_rsp("rsp_at_done");
    req_write = 1'b0; req_read = '0;
    @(posedge clk); #1;
    chk("idle_after_done", 32'(dbg_state), 32'd0);
    chk("idle_clken", 32'(cpu_clken), 32'd1);
  endtask

  initial begin
    logic [NR*AW-1:0] ra;
    logic [NR-1:0]    rm;
    logic             wr;
    for (int a = 0; a < (1 << AW); a++) begin
      ram[a]     = DW'($urandom);
      ref_mem[a] = ram[a];
    end
    ram[5] = 10'h03A; ram[1] = 10'h011; ram[2] = 10'h012; ram[3] = 10'h013; ram[4] = 10'h014;
    ram[7] = 10'h100;
    for (int a = 1; a <= 7; a++) ref_mem[a] = ram[a];
    for (int k = 0; k < int'(NR); k++) exp_rsp[k] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_clken", 32'(cpu_clken), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk_rsp("rst_rsp");
    @(negedge clk) rst = 1'b1;

    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("idle_clken_hi", 32'(cpu_clken), 32'd1);
      chk("idle_no_ram", 32'(ram_en), 32'd0);
    end

    run_txn(1'b0, '0, '0, 4'b0001, {14'd0, 14'd0, 14'd0, 14'd5});
    run_txn(1'b0, '0, '0, 4'b1111, {14'd4, 14'd3, 14'd2, 14'd1});
    run_txn(1'b1, 14'd7, 10'h2FF, 4'b0001, {14'd0, 14'd0, 14'd0, 14'd7});
    run_txn(1'b0, '0, '0, 4'b0001, {14'd0, 14'd0, 14'd0, 14'd7});
    run_txn(1'b1, 14'h3FFF, 10'h155, 4'b0000, '0);
    run_txn(1'b0, '0, '0, 4'b1010, {14'h3FFF, 14'd9, 14'h3FFF, 14'd9});

    for (int t = 0; t < 40; t++) begin
      rm = NR'($urandom);
      wr = 1'($urandom);
      if (rm == '0 && !wr) rm = 4'b0100;
      for (int k = 0; k < int'(NR); k++) ra[k*AW +: AW] = AW'($urandom_range(0, 15));
      run_txn(wr, AW'($urandom_range(0, 15)), DW'($urandom), rm, ra);
    end

    // Reset in the middle of a 4-read transaction
    @(negedge clk);
    req_read = 4'b1111; req_outaddr = {14'd4, 14'd3, 14'd2, 14'd1}; req_write = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("mid_issuing", 32'(ram_en), 32'd1);
    rst = 1'b0; #1;
    chk("abort_ram_en", 32'(ram_en), 32'd0);
    chk("abort_clken", 32'(cpu_clken), 32'd0);
    for (int k = 0; k < int'(NR); k++) exp_rsp[k] = '0;
    chk_rsp("abort_rsp");
    req_read = '0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("post_abort_state", 32'(dbg_state), 32'd0);
    chk("post_abort_clken", 32'(cpu_clken), 32'd1);
    run_txn(1'b0, '0, '0, 4'b0100, {14'd0, 14'd5, 14'd0, 14'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
